auth_code_fsm: RTL
==================

// Module: auth_code_fsm
// PURPOSE
//  Consumes the 1-cycle rising-edge pulses produced by the per-button edge detectors (one per key).
//  Collects an N-digit key sequence and compares it against a fixed secret.
//  Grants a timed unlock, counts failed attempts, and enforces a timed lockout after MAX_FAILS misses.
//  Sits between the button edge-detect stage and the top-level status/LED outputs.
// PARAMETERS
//  N_DIGITS       4         digits per code (1..7)
//  SECRET         8'hE4     code; SECRET[2i+1:2i] = digit i, i=0 entered first (default 0,1,2,3)
//  MAX_FAILS      3         consecutive failed attempts that trigger lockout (>=1)
//  UNLOCK_CYCLES  1000      cycles unlock stays high after a correct code (>=1)
//  LOCK_CYCLES    10000     cycles of lockout (>=1)
//  TIMEOUT_CYCLES 5000      max idle cycles between digits before the entry is abandoned (>=1)
// PORTS
//  clk            in   1        system clock
//  reset          in   1        asynchronous, active-high reset
//  key_pulse      in   4        edge pulses; bit k high for one cycle = key k pressed (digit value k)
//  unlock         out  1        high while access granted
//  deny           out  1        1-cycle pulse on a wrong code
//  locked         out  1        high during lockout
//  busy           out  1        high while an entry is in progress (ENTRY state)
//  digits_entered out  CW       digits taken in the current attempt, CW=$clog2(N_DIGITS+1)
//  fail_count     out  FW       consecutive failures, FW=$clog2(MAX_FAILS+1)
// BEHAVIOUR
//  Single clock; reset is asynchronous, active-high. All outputs are registered.
//  Reset (any time, including mid-entry, unlock or lockout): state=IDLE; all outputs 0;
//    digit and mismatch registers cleared; all timers cleared.
//  Press = key_pulse!=0 in a cycle. One-hot press gives digit = index of the set bit.
//    A multi-bit press counts as one digit and forces mismatch.
//  States:
//   IDLE: wait for a press. On a press: take digit 0, go to ENTRY, digits_entered=1.
//   ENTRY (busy=1): each press takes the next digit.
//     mismatch |= (digit != SECRET slice).
//     No early reject; all N_DIGITS must be entered.
//     After the N_DIGITS-th press, go to CHECK.
//     Idle timer counts cycles without a press and is reloaded on each press.
//     Timer reaching TIMEOUT_CYCLES: go to IDLE, digits cleared, fail_count unchanged, no deny.
//     With N_DIGITS=1, go directly from IDLE to CHECK.
//   CHECK (1 cycle): if mismatch, fail_count+1.
//     Correct code: go to GRANT, fail_count=0.
//     Wrong code and fail_count+1 == MAX_FAILS: go to LOCKOUT.
//     Wrong code otherwise: go to DENY.
//     digits_entered clears to 0 on entering CHECK.
//   GRANT: unlock=1 for exactly UNLOCK_CYCLES cycles, then go to IDLE. Presses ignored.
//   DENY: deny=1 for exactly 1 cycle, then go to IDLE.
//   LOCKOUT: locked=1 for exactly LOCK_CYCLES cycles. Presses ignored.
//     Exit to IDLE with fail_count=0. deny is not pulsed on entry to lockout.
//  Latency: final digit press in cycle t -> CHECK at t+1 -> unlock/deny/locked first high at t+2.
//  A press in the same cycle as the timeout boundary counts as a press; no timeout occurs.
//  Presses arriving in CHECK/DENY are ignored.
//  Timers saturate at their terminal value; they never wrap.
// TESTING (bench params: UNLOCK=8, LOCK=20, TIMEOUT=16, defaults otherwise)
//  Keys 0,1,2,3 one cycle apart -> unlock high cycles t+2..t+9, fail_count=0, deny never high.
//  Keys 0,1,3,3 -> deny high only at t+2, fail_count=1, unlock stays 0.
//  Three wrong codes -> deny after attempts 1 and 2; attempt 3 gives locked=1 for 20 cycles.
//    Presses during lockout ignored; then fail_count=0; correct code then unlocks.
//  Keys 0,1 then 16 idle cycles -> busy drops, digits_entered=0, fail_count unchanged.
//    Fresh 0,1,2,3 then unlocks.
//  key_pulse=4'b0011 as digit 0, then 1,2,3 -> deny, fail_count=1.
//  Reset asserted mid-entry after 2 digits and mid-GRANT -> all outputs 0 asynchronously.
//    After release, correct code unlocks normally.

Source files
------------

// File: rtl/auth_code_if.sv
// Key-pulse input and status outputs of the code-entry lock.
// The slave side is the lock FSM; the master side drives key pulses and observes status.
interface auth_code_if #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned CW = $clog2(N_DIGITS + 1);
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);

  logic [3:0]    key_pulse;
  logic          unlock;
  logic          deny;
  logic          locked;
  logic          busy;
  logic [CW-1:0] digits_entered;
  logic [FW-1:0] fail_count;

  modport master (
    output key_pulse,
    input  unlock, deny, locked, busy, digits_entered, fail_count
  );

  modport slave (
    input  key_pulse,
    output unlock, deny, locked, busy, digits_entered, fail_count
  );
endinterface

// File: rtl/auth_code_fsm.sv
// Collects an N-digit key sequence from edge-detected button pulses, checks it against a
// fixed secret, and manages timed unlock, consecutive-failure counting and timed lockout.
module auth_code_fsm #(
  parameter int unsigned           N_DIGITS       = 4,
  parameter logic [2*N_DIGITS-1:0] SECRET         = 8'hE4,
  parameter int unsigned           MAX_FAILS      = 3,
  parameter int unsigned           UNLOCK_CYCLES  = 1000,
  parameter int unsigned           LOCK_CYCLES    = 10000,
  parameter int unsigned           TIMEOUT_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             reset,
  auth_code_if.slave       bus
);
  localparam int unsigned CW    = $clog2(N_DIGITS + 1);
  localparam int unsigned FW    = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMAX0 = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int unsigned TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_GRANT, S_DENY, S_LOCKOUT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] digits_q, digits_d;
  logic          mismatch_q, mismatch_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          unlock_q, deny_q, locked_q, busy_q;

  logic       press;
  logic       multi;
  logic [1:0] digit;
  logic [1:0] secret_digit;
  logic       bad_digit;

  // A multi-bit press still counts as one digit but can never match.
  assign press        = |bus.key_pulse;
  assign multi        = (bus.key_pulse & (bus.key_pulse - 4'd1)) != 4'd0;
  assign secret_digit = 2'(SECRET >> {digits_q, 1'b0});
  assign bad_digit    = multi || (digit != secret_digit);

  always_comb begin
    digit = 2'd0;
    if (bus.key_pulse[1]) digit = 2'd1;
    if (bus.key_pulse[2]) digit = 2'd2;
    if (bus.key_pulse[3]) digit = 2'd3;
  end

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (press) begin
          mismatch_d = bad_digit;
          if (N_DIGITS == 1) begin
            state_d  = S_CHECK;
            digits_d = '0;
          end else begin
            state_d  = S_ENTRY;
            digits_d = CW'(1);
          end
        end
      end
      S_ENTRY: begin
        // A press on the timeout boundary wins over the timeout.
        if (press) begin
          mismatch_d = mismatch_q | bad_digit;
          timer_d    = '0;
          if (digits_q == CW'(N_DIGITS - 1)) begin
            state_d  = S_CHECK;
            digits_d = '0;
          end else begin
            digits_d = digits_q + CW'(1);
          end
        end else if (timer_q >= TW'(TIMEOUT_CYCLES - 1)) begin
          state_d    = S_IDLE;
          digits_d   = '0;
          mismatch_d = 1'b0;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CHECK: begin
        timer_d    = '0;
        mismatch_d = 1'b0;
        if (!mismatch_q) begin
          fail_d  = '0;
          state_d = S_GRANT;
        end else begin
          fail_d  = fail_q + FW'(1);
          state_d = (fail_q + FW'(1) == FW'(MAX_FAILS)) ? S_LOCKOUT : S_DENY;
        end
      end
      S_GRANT: begin
        if (timer_q >= TW'(UNLOCK_CYCLES - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DENY: state_d = S_IDLE;
      S_LOCKOUT: begin
        if (timer_q >= TW'(LOCK_CYCLES - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
          fail_d  = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      digits_q   <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= '0;
      timer_q    <= '0;
      unlock_q   <= 1'b0;
      deny_q     <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      unlock_q   <= (state_d == S_GRANT);
      deny_q     <= (state_d == S_DENY);
      locked_q   <= (state_d == S_LOCKOUT);
      busy_q     <= (state_d == S_ENTRY);
    end
  end

  assign bus.unlock         = unlock_q;
  assign bus.deny           = deny_q;
  assign bus.locked         = locked_q;
  assign bus.busy           = busy_q;
  assign bus.digits_entered = digits_q;
  assign bus.fail_count     = fail_q;
endmodule
